// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/ALU/response bundle for the execute-stage ALU arbiter
//
// Purpose: groups both requester handshakes, the ALU operand/result lines and
// the response handshake into one interface.
// Modports:
//   slave  - the arbiter view (takes requests, drives the ALU, produces responses)
//   master - the environment view (requesters, ALU instance, response consumer)
// Signals:
//   reqN_valid/ready/a/b/ctrl  requester N operation handshake (N = 0, 1)
//   alu_a/alu_b/alu_ctrl       operands/control to the combinational ALU
//   alu_result/alu_zero        ALU outputs
//   rsp_valid/ready/id/result/zero  registered response handshake

interface alu_arbiter_if #(
    parameter int WIDTH  = 64,
    parameter int CTRL_W = 4
);
    logic              req0_valid;
    logic              req0_ready;
    logic [WIDTH-1:0]  req0_a;
    logic [WIDTH-1:0]  req0_b;
    logic [CTRL_W-1:0] req0_ctrl;

    logic              req1_valid;
    logic              req1_ready;
    logic [WIDTH-1:0]  req1_a;
    logic [WIDTH-1:0]  req1_b;
    logic [CTRL_W-1:0] req1_ctrl;

    logic [WIDTH-1:0]  alu_a;
    logic [WIDTH-1:0]  alu_b;
    logic [CTRL_W-1:0] alu_ctrl;
    logic [WIDTH-1:0]  alu_result;
    logic              alu_zero;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [WIDTH-1:0]  rsp_result;
    logic              rsp_zero;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctrl,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_ctrl,
        output req1_ready,
        output alu_a, alu_b, alu_ctrl,
        input  alu_result, alu_zero,
        output rsp_valid, rsp_id, rsp_result, rsp_zero,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_ctrl,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_ctrl,
        input  req1_ready,
        input  alu_a, alu_b, alu_ctrl,
        output alu_result, alu_zero,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin share of the execute-stage ALU between two requesters
//
// Purpose: grants one of two requesters per cycle, muxes its operands onto the
// combinational ALU and captures the result into a one-entry response register
// tagged with the requester id.
// Ports:
//   clk    - single clock, rising edge
//   reset  - synchronous, active-high
//   bus    - alu_arbiter_if.slave (requests, ALU lines, response)
// Parameters:
//   WIDTH    operand/result width
//   CTRL_W   ALU control width
//   ALU_AND  control code driven while idle

module alu_arbiter #(
    parameter int                WIDTH   = 64,
    parameter int                CTRL_W  = 4,
    parameter logic [CTRL_W-1:0] ALU_AND = '0
) (
    input  logic        clk,
    input  logic        reset,
    alu_arbiter_if.slave bus
);

    logic              last_grant;
    logic              slot_free;
    logic              grant0;
    logic              grant1;

    logic              rsp_valid_q;
    logic              rsp_id_q;
    logic [WIDTH-1:0]  rsp_result_q;
    logic              rsp_zero_q;

    // The slot may be refilled in the same cycle the consumer drains it.
    assign slot_free = !rsp_valid_q || bus.rsp_ready;

    // Under contention the requester that did not win last time goes next.
    // Grants are held off during reset so nothing completes in that cycle.
    assign grant0 = !reset && slot_free && bus.req0_valid &&
                    (!bus.req1_valid || last_grant);
    assign grant1 = !reset && slot_free && bus.req1_valid &&
                    (!bus.req0_valid || !last_grant);

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    // Idle drives a constant AND of zeros so the ALU inputs stay quiet.
    always_comb begin
        bus.alu_a    = '0;
        bus.alu_b    = '0;
        bus.alu_ctrl = ALU_AND;
        if (grant0) begin
            bus.alu_a    = bus.req0_a;
            bus.alu_b    = bus.req0_b;
            bus.alu_ctrl = bus.req0_ctrl;
        end else if (grant1) begin
            bus.alu_a    = bus.req1_a;
            bus.alu_b    = bus.req1_b;
            bus.alu_ctrl = bus.req1_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            last_grant   <= 1'b1;
        end else if (grant0 || grant1) begin
            rsp_valid_q  <= 1'b1;
            rsp_id_q     <= grant1;
            rsp_result_q <= bus.alu_result;
            rsp_zero_q   <= bus.alu_zero;
            last_grant   <= grant1;
        end else if (bus.rsp_ready) begin
            // Drain with nothing new: data registers keep their last value.
            rsp_valid_q  <= 1'b0;
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;

endmodule
